breakout_sfx_gen: RTL and testbench



---
 rtl/breakout_sfx_gen_pkg.sv | 13 +
 rtl/breakout_sfx_gen_if.sv | 26 ++
 rtl/breakout_sfx_gen_pick.sv | 21 ++
 rtl/breakout_sfx_gen.sv | 152 +++++++++++++++
 tb/tb_breakout_sfx_gen.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/breakout_sfx_gen_pkg.sv
// Shared types and default tone constants for the breakout sound-effect generator.
package breakout_sfx_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    PLAY = 1'b1
  } sfx_state_t;

  localparam logic [15:0] SFX_HALF_COLLIDE = 16'd25000;
  localparam logic [15:0] SFX_HALF_BRICK   = 16'd12500;
  localparam logic [21:0] SFX_DUR_DEFAULT  = 22'd2500000;

endpackage

// File: rtl/breakout_sfx_gen_if.sv
// Trigger/config/status bundle between the game logic and the sound-effect generator.
interface breakout_sfx_gen_if #(
  parameter int NUM_EVENTS = 2,
  parameter int DIV_W      = 16,
  parameter int DUR_W      = 22,
  parameter int ID_W       = 1
);
  logic [NUM_EVENTS-1:0]       event_trig;
  logic [NUM_EVENTS*DIV_W-1:0] tone_half_period;
  logic [DUR_W-1:0]            tone_duration;
  logic                        mute;
  logic                        audio_l;
  logic                        audio_r;
  logic                        busy;
  logic [ID_W-1:0]             active_id;

  modport master (
    output event_trig, tone_half_period, tone_duration, mute,
    input  audio_l, audio_r, busy, active_id
  );

  modport slave (
    input  event_trig, tone_half_period, tone_duration, mute,
    output audio_l, audio_r, busy, active_id
  );
endinterface

// File: rtl/breakout_sfx_gen_pick.sv
// Highest-index-wins encoder: reports whether any rise is present and which one wins.
module sfx_priority_pick #(
  parameter int NUM_EVENTS = 2,
  parameter int ID_W       = 1
) (
  input  logic [NUM_EVENTS-1:0] i_rise,
  output logic                  o_valid,
  output logic [ID_W-1:0]       o_index
);

  // Later (higher) indices overwrite earlier ones, so the top set bit wins.
  always_comb begin
    o_valid = 1'b0;
    o_index = {ID_W{1'b0}};
    for (int i = 0; i < NUM_EVENTS; i++) begin
      o_valid = o_valid | i_rise[i];
      o_index = i_rise[i] ? ID_W'(i) : o_index;
    end
  end

endmodule

// File: rtl/breakout_sfx_gen.sv
// Priority-arbitrated one-shot square-wave player for the breakout audio pins.
// Define SFX_SWEEP_EN to lengthen each level by one cycle per toggle (falling pitch).
module breakout_sfx_gen
  import breakout_sfx_pkg::*;
#(
  parameter int NUM_EVENTS = 2,
  parameter int DIV_W      = 16,
  parameter int DUR_W      = 22,
  parameter int ID_W       = 1
) (
  input  logic               clk,
  input  logic               reset,
  breakout_sfx_gen_if.slave  bus
);

  logic [NUM_EVENTS-1:0] r_trig_q;
  logic [NUM_EVENTS-1:0] w_rise;
  logic                  w_win_valid;
  logic [ID_W-1:0]       w_win_id;
  sfx_state_t            r_state, w_state_n;
  logic                  r_sq, w_sq_n;
  logic [DIV_W-1:0]      r_half_cnt, w_half_n;
  logic [DUR_W-1:0]      r_dur_cnt, w_dur_n;
  logic [ID_W-1:0]       r_active_id, w_id_n;
  logic                  r_busy, r_audio;
  logic                  w_load, w_stop, w_toggle;
  logic [DIV_W-1:0]      w_load_half, w_reload_half;

  function automatic logic [DIV_W-1:0] half_of(input logic [NUM_EVENTS*DIV_W-1:0] vec,
                                               input logic [ID_W-1:0] idx);
    return vec[int'(idx)*DIV_W +: DIV_W];
  endfunction

  // A zero half-period behaves like one, so a level always lasts at least a cycle.
  function automatic logic [DIV_W-1:0] cnt_of(input logic [DIV_W-1:0] h);
    return (h == {DIV_W{1'b0}}) ? {DIV_W{1'b0}} : h - DIV_W'(1);
  endfunction

  assign w_rise = bus.event_trig & ~r_trig_q;

  sfx_priority_pick #(.NUM_EVENTS(NUM_EVENTS), .ID_W(ID_W)) u_pick (
    .i_rise  (w_rise),
    .o_valid (w_win_valid),
    .o_index (w_win_id)
  );

  assign w_load_half = cnt_of(half_of(bus.tone_half_period, w_win_id));

`ifdef SFX_SWEEP_EN
  logic [DIV_W-1:0] r_off [NUM_EVENTS];
  logic [DIV_W-1:0] w_off_inc;
  logic [DIV_W:0]   w_sum;

  assign w_off_inc     = (r_off[r_active_id] == {DIV_W{1'b1}}) ? r_off[r_active_id]
                                                                : r_off[r_active_id] + DIV_W'(1);
  assign w_sum         = {1'b0, half_of(bus.tone_half_period, r_active_id)} + {1'b0, w_off_inc};
  assign w_reload_half = cnt_of(w_sum[DIV_W] ? {DIV_W{1'b1}} : w_sum[DIV_W-1:0]);

  // Sweep offsets: cleared when their event (re)starts, bumped on every toggle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_EVENTS; i++) r_off[i] <= {DIV_W{1'b0}};
    end else if (w_load) begin
      r_off[w_win_id] <= {DIV_W{1'b0}};
    end else if (w_toggle) begin
      r_off[r_active_id] <= w_off_inc;
    end
  end
`else
  assign w_reload_half = cnt_of(half_of(bus.tone_half_period, r_active_id));
`endif

  // Next-state logic; preemption is checked before expiry so a new winner always wins.
  always_comb begin
    w_state_n = r_state;
    w_sq_n    = r_sq;
    w_half_n  = r_half_cnt;
    w_dur_n   = r_dur_cnt;
    w_id_n    = r_active_id;
    w_load    = 1'b0;
    w_stop    = 1'b0;
    w_toggle  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_valid && (bus.tone_duration != {DUR_W{1'b0}})) w_load = 1'b1;
        else w_load = 1'b0;
      end
      PLAY: begin
        if (w_win_valid && (w_win_id >= r_active_id)) begin
          if (bus.tone_duration != {DUR_W{1'b0}}) w_load = 1'b1;
          else w_stop = 1'b1;
        end else if (r_dur_cnt == {DUR_W{1'b0}}) begin
          w_stop = 1'b1;
        end else begin
          w_dur_n = r_dur_cnt - DUR_W'(1);
          if (r_half_cnt == {DIV_W{1'b0}}) begin
            w_toggle = 1'b1;
            w_half_n = w_reload_half;
          end else begin
            w_half_n = r_half_cnt - DIV_W'(1);
          end
        end
      end
      default: w_stop = 1'b1;
    endcase
    if (w_load) begin
      w_state_n = PLAY;
      w_sq_n    = 1'b1;
      w_half_n  = w_load_half;
      w_dur_n   = bus.tone_duration - DUR_W'(1);
      w_id_n    = w_win_id;
    end else if (w_stop) begin
      w_state_n = IDLE;
      w_sq_n    = 1'b0;
      w_half_n  = {DIV_W{1'b0}};
      w_dur_n   = {DUR_W{1'b0}};
      w_id_n    = {ID_W{1'b0}};
    end else begin
      w_state_n = r_state;
      w_sq_n    = r_sq ^ w_toggle;
    end
  end

  // State, counters and registered pins; audio follows next sq so it lines up with busy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_trig_q    <= {NUM_EVENTS{1'b0}};
      r_state     <= IDLE;
      r_sq        <= 1'b0;
      r_half_cnt  <= {DIV_W{1'b0}};
      r_dur_cnt   <= {DUR_W{1'b0}};
      r_active_id <= {ID_W{1'b0}};
      r_busy      <= 1'b0;
      r_audio     <= 1'b0;
    end else begin
      r_trig_q    <= bus.event_trig;
      r_state     <= w_state_n;
      r_sq        <= w_sq_n;
      r_half_cnt  <= w_half_n;
      r_dur_cnt   <= w_dur_n;
      r_active_id <= w_id_n;
      r_busy      <= (w_state_n == PLAY);
      r_audio     <= w_sq_n & ~bus.mute;
    end
  end

  assign bus.audio_l   = r_audio;
  assign bus.audio_r   = r_audio;
  assign bus.busy      = r_busy;
  assign bus.active_id = r_active_id;

endmodule

// File: tb/tb_breakout_sfx_gen.sv
// Directed self-checking bench for breakout_sfx_gen (H0 = 4, H1 = 2, duration = 20).
module tb_breakout_sfx_gen;

  localparam int NE = 2;
  localparam int DW = 16;
  localparam int UW = 22;
  localparam int IW = 1;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_pass   = 0;

  breakout_sfx_gen_if #(.NUM_EVENTS(NE), .DIV_W(DW), .DUR_W(UW), .ID_W(IW)) sfx_if ();

  breakout_sfx_gen #(.NUM_EVENTS(NE), .DIV_W(DW), .DUR_W(UW), .ID_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (sfx_if)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference square wave: level k of the tone, first level high, each level h cycles long.
  function automatic logic exp_sq(input int k, input int h);
    int   len;
    int   pos;
    logic lvl;
    len = (h < 1) ? 1 : h;
    pos = 0;
    lvl = 1'b1;
    while (k >= pos + len) begin
      pos += len;
      lvl = ~lvl;
`ifdef SFX_SWEEP_EN
      len++;
`endif
    end
    return lvl;
  endfunction

  function automatic logic [31:0] obs();
    return {28'd0, sfx_if.busy, sfx_if.active_id, sfx_if.audio_l, sfx_if.audio_r};
  endfunction

  function automatic logic [31:0] exp_play(input int id, input int k, input int h, input bit m);
    logic a;
    a = exp_sq(k, h) & ~m;
    return {28'd0, 1'b1, id[0], a, a};
  endfunction

  // Walks the 20 busy cycles of a tone; optional mute window and a side trigger on event 0.
  task automatic play_check(input string tag, input int id, input int h,
                            input int mf, input int mt, input int ton, input int toff);
    for (int k = 0; k < 20; k++) begin
      check_val(tag, obs(), exp_play(id, k, h, (k >= mf + 1) && (k <= mt)));
      if (k == mf) sfx_if.mute = 1'b1;
      if (k == mt) sfx_if.mute = 1'b0;
      if (k == ton) sfx_if.event_trig = 2'b01;
      if (k == toff) sfx_if.event_trig = 2'b00;
      tick();
    end
  endtask

  initial begin
    reset                   = 1'b1;
    sfx_if.event_trig       = 2'b00;
    sfx_if.tone_half_period = {16'd2, 16'd4};
    sfx_if.tone_duration    = 22'd20;
    sfx_if.mute             = 1'b0;
    tick();
    tick();
    check_val("rst_hold", obs(), 32'd0);
    reset = 1'b0;
    tick();
    check_val("rst_rel", obs(), 32'd0);

    // Basic tone on event 0
    sfx_if.event_trig = 2'b01;
    tick();
    sfx_if.event_trig = 2'b00;
    play_check("t2_wave", 0, 4, -1, -1, -1, -1);
    check_val("t2_end", obs(), 32'd0);

    // Event 1 preempts event 0 and restarts the duration
    sfx_if.event_trig = 2'b01;
    tick();
    sfx_if.event_trig = 2'b00;
    repeat (4) tick();
    check_val("t3_pre", obs(), exp_play(0, 4, 4, 1'b0));
    sfx_if.event_trig = 2'b10;
    tick();
    sfx_if.event_trig = 2'b00;
    play_check("t3_wave", 1, 2, -1, -1, -1, -1);
    check_val("t3_end", obs(), 32'd0);

    // Lower-priority rise during event 1 is ignored
    sfx_if.event_trig = 2'b10;
    tick();
    sfx_if.event_trig = 2'b00;
    play_check("t4_ignore", 1, 2, -1, -1, 3, 5);
    check_val("t4_end", obs(), 32'd0);

    // Simultaneous rises in IDLE: event 1 wins
    sfx_if.event_trig = 2'b11;
    tick();
    sfx_if.event_trig = 2'b00;
    check_val("t4_both", obs(), exp_play(1, 0, 2, 1'b0));
    repeat (19) tick();
    check_val("t4_both_last", obs(), exp_play(1, 19, 2, 1'b0));
    tick();
    check_val("t4_both_end", obs(), 32'd0);

    // Mute window keeps busy and phase
    sfx_if.event_trig = 2'b01;
    tick();
    sfx_if.event_trig = 2'b00;
    play_check("t5_mute", 0, 4, 5, 9, -1, -1);
    check_val("t5_end", obs(), 32'd0);

    // Zero duration: IDLE trigger ignored, preempting trigger terminates
    sfx_if.tone_duration = 22'd0;
    sfx_if.event_trig    = 2'b01;
    tick();
    check_val("t5_dur0_a", obs(), 32'd0);
    sfx_if.event_trig = 2'b00;
    tick();
    check_val("t5_dur0_b", obs(), 32'd0);
    sfx_if.tone_duration = 22'd20;
    sfx_if.event_trig    = 2'b01;
    tick();
    sfx_if.event_trig = 2'b00;
    tick();
    tick();
    check_val("t5_kill_pre", obs(), exp_play(0, 2, 4, 1'b0));
    sfx_if.tone_duration = 22'd0;
    sfx_if.event_trig    = 2'b10;
    tick();
    check_val("t5_kill", obs(), 32'd0);
    sfx_if.event_trig    = 2'b00;
    sfx_if.tone_duration = 22'd20;
    tick();

    // Held-high trigger plays once only
    sfx_if.event_trig = 2'b01;
    tick();
    play_check("t6_held", 0, 4, -1, -1, -1, -1);
    check_val("t6_end", obs(), 32'd0);
    repeat (5) tick();
    check_val("t6_hold", obs(), 32'd0);
    sfx_if.event_trig = 2'b00;
    tick();

    // Asynchronous reset in the middle of a tone
    sfx_if.event_trig = 2'b01;
    tick();
    sfx_if.event_trig = 2'b00;
    tick();
    tick();
    check_val("t1_play", obs(), exp_play(0, 2, 4, 1'b0));
    #2;
    reset = 1'b1;
    #1;
    check_val("t1_async", obs(), 32'd0);
    tick();
    reset = 1'b0;
    repeat (3) tick();
    check_val("t1_after", obs(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
